// File: rtl/mux2_1_merge.sv
// Registered 2-to-1 stream merger with round-robin or forced arbitration.
// Output word is tagged with its source; per-source accept counters.
module mux2_1_merge #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] IN_A,
   input  logic                  VALID_A,
   output logic                  READY_A,
   input  logic [DATA_WIDTH-1:0] IN_B,
   input  logic                  VALID_B,
   output logic                  READY_B,
   input  logic                  SEL_FORCE,
   input  logic                  Select_line,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic                  OUT_VALID,
   output logic                  OUT_SEL,
   input  logic                  OUT_READY,
   output logic [CNT_WIDTH-1:0]  CNT_A,
   output logic [CNT_WIDTH-1:0]  CNT_B
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_sel;
   logic                  r_last;
   logic [CNT_WIDTH-1:0]  r_cnt_a;
   logic [CNT_WIDTH-1:0]  r_cnt_b;

   logic w_load;
   logic w_elig_a;
   logic w_elig_b;
   logic w_req_a;
   logic w_req_b;
   logic w_gnt_a;
   logic w_gnt_b;

   assign w_load   = !r_valid || OUT_READY;
   assign w_elig_a = !SEL_FORCE || !Select_line;
   assign w_elig_b = !SEL_FORCE || Select_line;

   // RESET gates the requests so no handshake completes during reset.
   assign w_req_a = RESET && w_load && w_elig_a && VALID_A;
   assign w_req_b = RESET && w_load && w_elig_b && VALID_B;

   // r_last = 1 means B was granted last, so A wins a tie.
   assign w_gnt_a = w_req_a && (!w_req_b || r_last);
   assign w_gnt_b = w_req_b && (!w_req_a || !r_last);

   assign READY_A = w_gnt_a;
   assign READY_B = w_gnt_b;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sel   <= 1'b0;
         r_last  <= 1'b1;
         r_cnt_a <= '0;
         r_cnt_b <= '0;
      end else if (w_gnt_a) begin
         r_data  <= IN_A;
         r_valid <= 1'b1;
         r_sel   <= 1'b0;
         r_last  <= 1'b0;
         r_cnt_a <= r_cnt_a + 1'b1;
      end else if (w_gnt_b) begin
         r_data  <= IN_B;
         r_valid <= 1'b1;
         r_sel   <= 1'b1;
         r_last  <= 1'b1;
         r_cnt_b <= r_cnt_b + 1'b1;
      end else if (w_load) begin
         r_valid <= 1'b0;
      end
   end

   assign OUT_DATA  = r_data;
   assign OUT_VALID = r_valid;
   assign OUT_SEL   = r_sel;
   assign CNT_A     = r_cnt_a;
   assign CNT_B     = r_cnt_b;

endmodule

// File: tb/tb_mux2_1_merge.sv
// Directed testbench for mux2_1_merge: vector table plus
// hand-written reset and counter-wrap sequences.
module tb_mux2_1_merge;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] IN_A, IN_B;
   logic       VALID_A, VALID_B;
   logic       READY_A, READY_B;
   logic       SEL_FORCE, Select_line;
   logic [7:0] OUT_DATA;
   logic       OUT_VALID, OUT_SEL, OUT_READY;
   logic [7:0] CNT_A, CNT_B;

   int n_cmp = 0;
   int n_bad = 0;

   mux2_1_merge #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .CLK(CLK), .RESET(RESET),
      .IN_A(IN_A), .VALID_A(VALID_A), .READY_A(READY_A),
      .IN_B(IN_B), .VALID_B(VALID_B), .READY_B(READY_B),
      .SEL_FORCE(SEL_FORCE), .Select_line(Select_line),
      .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
      .OUT_SEL(OUT_SEL), .OUT_READY(OUT_READY),
      .CNT_A(CNT_A), .CNT_B(CNT_B)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       va, vb;
      logic [7:0] a, b;
      logic       f, s, ordy;
      logic       ra, rb;
      logic       ov;
      logic [7:0] od;
      logic       os;
      logic [7:0] ca, cb;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input int idx,
                      input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic va, input logic vb,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic f, input logic s, input logic ordy);
      VALID_A = va; VALID_B = vb;
      IN_A = a; IN_B = b;
      SEL_FORCE = f; Select_line = s;
      OUT_READY = ordy;
   endtask

   initial begin
      //          va vb a      b      f  s  or  ra rb ov od     os ca  cb
      vecs[0]  = '{1, 1, 8'h11, 8'h22, 0, 0, 1,  1, 0, 1, 8'h11, 0, 8'd1, 8'd0};
      vecs[1]  = '{1, 1, 8'h11, 8'h22, 0, 0, 1,  0, 1, 1, 8'h22, 1, 8'd1, 8'd1};
      vecs[2]  = '{1, 1, 8'h11, 8'h22, 0, 0, 1,  1, 0, 1, 8'h11, 0, 8'd2, 8'd1};
      vecs[3]  = '{1, 1, 8'h11, 8'h22, 0, 0, 1,  0, 1, 1, 8'h22, 1, 8'd2, 8'd2};
      vecs[4]  = '{0, 1, 8'h11, 8'h5A, 0, 0, 1,  0, 1, 1, 8'h5A, 1, 8'd2, 8'd3};
      vecs[5]  = '{1, 1, 8'h11, 8'h22, 0, 0, 0,  0, 0, 1, 8'h5A, 1, 8'd2, 8'd3};
      vecs[6]  = '{1, 1, 8'h11, 8'h22, 0, 0, 0,  0, 0, 1, 8'h5A, 1, 8'd2, 8'd3};
      vecs[7]  = '{1, 1, 8'h11, 8'h22, 0, 0, 0,  0, 0, 1, 8'h5A, 1, 8'd2, 8'd3};
      vecs[8]  = '{1, 1, 8'h11, 8'h22, 0, 0, 1,  1, 0, 1, 8'h11, 0, 8'd3, 8'd3};
      vecs[9]  = '{1, 1, 8'h11, 8'h22, 1, 1, 1,  0, 1, 1, 8'h22, 1, 8'd3, 8'd4};
      vecs[10] = '{1, 1, 8'h11, 8'h22, 1, 1, 1,  0, 1, 1, 8'h22, 1, 8'd3, 8'd5};
      vecs[11] = '{1, 1, 8'h11, 8'h22, 1, 1, 1,  0, 1, 1, 8'h22, 1, 8'd3, 8'd6};
      vecs[12] = '{0, 1, 8'h77, 8'h66, 1, 0, 1,  0, 0, 0, 8'h22, 1, 8'd3, 8'd6};
      vecs[13] = '{0, 0, 8'h77, 8'h66, 0, 0, 0,  0, 0, 0, 8'h22, 1, 8'd3, 8'd6};
      vecs[14] = '{0, 1, 8'h77, 8'h44, 0, 0, 0,  0, 1, 1, 8'h44, 1, 8'd3, 8'd7};
      vecs[15] = '{1, 0, 8'h55, 8'h44, 0, 0, 0,  0, 0, 1, 8'h44, 1, 8'd3, 8'd7};
      vecs[16] = '{1, 0, 8'h55, 8'h44, 0, 0, 1,  1, 0, 1, 8'h55, 0, 8'd4, 8'd7};
      vecs[17] = '{0, 0, 8'h55, 8'h44, 0, 0, 1,  0, 0, 0, 8'h55, 0, 8'd4, 8'd7};

      // Reset held with both sources valid and consumer ready
      RESET = 1'b0;
      drive(1, 1, 8'h11, 8'h22, 0, 0, 1);
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_ov", 0, {7'd0, OUT_VALID}, 8'd0);
      chk("rst_od", 0, OUT_DATA, 8'h00);
      chk("rst_os", 0, {7'd0, OUT_SEL}, 8'd0);
      chk("rst_ca", 0, CNT_A, 8'd0);
      chk("rst_cb", 0, CNT_B, 8'd0);
      chk("rst_ra", 0, {7'd0, READY_A}, 8'd0);
      chk("rst_rb", 0, {7'd0, READY_B}, 8'd0);
      @(negedge CLK);
      drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
      RESET = 1'b1;

      foreach (vecs[i]) begin
         @(negedge CLK);
         drive(vecs[i].va, vecs[i].vb, vecs[i].a, vecs[i].b,
               vecs[i].f, vecs[i].s, vecs[i].ordy);
         #1;
         chk("ready_a", i, {7'd0, READY_A}, {7'd0, vecs[i].ra});
         chk("ready_b", i, {7'd0, READY_B}, {7'd0, vecs[i].rb});
         @(posedge CLK);
         #1;
         chk("out_valid", i, {7'd0, OUT_VALID}, {7'd0, vecs[i].ov});
         chk("out_data", i, OUT_DATA, vecs[i].od);
         chk("out_sel", i, {7'd0, OUT_SEL}, {7'd0, vecs[i].os});
         chk("cnt_a", i, CNT_A, vecs[i].ca);
         chk("cnt_b", i, CNT_B, vecs[i].cb);
      end

      // Mid-operation reset: load 0x33, hold it, reset between edges
      @(negedge CLK);
      drive(1, 0, 8'h33, 8'h00, 0, 0, 1);
      @(posedge CLK);
      #1;
      chk("mid_load_od", 0, OUT_DATA, 8'h33);
      chk("mid_load_ov", 0, {7'd0, OUT_VALID}, 8'd1);
      @(negedge CLK);
      drive(1, 1, 8'h11, 8'h22, 0, 0, 0);
      #2;
      RESET = 1'b0;
      #1;
      chk("mid_rst_ov", 0, {7'd0, OUT_VALID}, 8'd0);
      chk("mid_rst_od", 0, OUT_DATA, 8'h00);
      chk("mid_rst_ca", 0, CNT_A, 8'd0);
      chk("mid_rst_cb", 0, CNT_B, 8'd0);
      @(negedge CLK);
      RESET = 1'b1;
      drive(1, 1, 8'h11, 8'h22, 0, 0, 1);
      #1;
      chk("post_rst_ra", 0, {7'd0, READY_A}, 8'd1);
      chk("post_rst_rb", 0, {7'd0, READY_B}, 8'd0);
      @(posedge CLK);
      #1;
      chk("post_rst_od", 0, OUT_DATA, 8'h11);
      chk("post_rst_os", 0, {7'd0, OUT_SEL}, 8'd0);

      // Counter wrap: 256 words from A after a fresh reset
      @(negedge CLK);
      drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      drive(1, 0, 8'hA5, 8'h00, 0, 0, 1);
      repeat (255) @(posedge CLK);
      #1;
      chk("wrap_ff", 0, CNT_A, 8'hFF);
      @(posedge CLK);
      #1;
      chk("wrap_a", 0, CNT_A, 8'h00);
      chk("wrap_b", 0, CNT_B, 8'h00);
      chk("wrap_od", 0, OUT_DATA, 8'hA5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux2_1_merge.md
Name: mux2_1_merge

Overview:
- Registered 2-to-1 stream merger. It is the collecting counterpart to the 1-to-2 demultiplexer in the ASIP datapath.
- Two 8-bit producer channels (A, B) with valid/ready handshakes are arbitrated round-robin, or forced by a select line, into one registered output channel. The output is tagged with its source.
- Per-source transfer counters support MAX/MIN/AVG result-path bookkeeping.

Parameters:
DATA_WIDTH, 8, width of data on every channel
CNT_WIDTH, 8, width of per-source accepted-transfer counters

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET  input  1  asynchronous, active-low reset (0 = reset asserted)
IN_A  input  DATA_WIDTH  channel A data
VALID_A  input  1  channel A data valid
READY_A  output  1  channel A accepted this cycle (combinational)
IN_B  input  DATA_WIDTH  channel B data
VALID_B  input  1  channel B data valid
READY_B  output  1  channel B accepted this cycle (combinational)
SEL_FORCE  input  1  1 = grant only the source named by Select_line; 0 = round-robin
Select_line  input  1  forced source: 0 = A, 1 = B
OUT_DATA  output  DATA_WIDTH  registered merged data
OUT_VALID  output  1  OUT_DATA holds an undelivered word
OUT_SEL  output  1  source tag of OUT_DATA: 0 = A, 1 = B
OUT_READY  input  1  consumer accepts OUT_DATA this cycle
CNT_A  output  CNT_WIDTH  words accepted from A, modulo 2^CNT_WIDTH
CNT_B  output  CNT_WIDTH  words accepted from B, modulo 2^CNT_WIDTH

Behaviour:
- Reset (RESET=0, asynchronous):
  - OUT_DATA=0, OUT_VALID=0, OUT_SEL=0, CNT_A=0, CNT_B=0.
  - Internal last_grant=1, so A wins the first contention.
  - Reset mid-transfer discards any held word; no handshake completes while RESET=0.
  - READY_A=READY_B=0 while RESET=0.
- load = !OUT_VALID | OUT_READY. This gives a single output register stage with full throughput: one word per cycle under continuous OUT_READY.
- Eligibility:
  - SEL_FORCE=1: only the source named by Select_line is eligible; the other source's READY stays 0.
  - SEL_FORCE=0: both sources are eligible.
- Grant (combinational, only when load=1):
  - Exactly one eligible valid source: grant that source.
  - Both eligible and valid: grant the source != last_grant.
  - READY_x=1 iff x is granted. READY may depend on VALID; producers must not make VALID depend on READY.
- On a clock edge with a grant to source s:
  - OUT_DATA<=IN_s, OUT_SEL<=s, OUT_VALID<=1.
  - last_grant<=s (last_grant updates only on a grant).
  - CNT_s<=CNT_s+1, wrapping 2^CNT_WIDTH-1 -> 0.
- On a clock edge with load=1 and no grant: OUT_VALID<=0. OUT_DATA and OUT_SEL hold their values.
- On a clock edge with load=0 (OUT_VALID=1, OUT_READY=0):
  - All outputs hold and READY_A=READY_B=0 (backpressure).
  - OUT_DATA must stay stable until it is accepted.
- Latency: an input accepted at edge n appears on OUT_DATA/OUT_VALID after edge n; it is consumable in the cycle following edge n.
- Simultaneous drain and load (OUT_VALID=1, OUT_READY=1, new grant): the output word is replaced and OUT_VALID stays 1. No bubble and no duplicate.
- SEL_FORCE or Select_line may change in any cycle; the change affects only the current cycle's grant. A held output word is never altered.

Test Plan:
- Reset: hold RESET=0 with VALID_A=VALID_B=1 and OUT_READY=1 -> OUT_VALID=0, OUT_DATA=0x00, CNT_A=CNT_B=0, READY_A=READY_B=0.
- Round-robin: VALID_A=VALID_B=1, IN_A=0x11, IN_B=0x22, OUT_READY=1 for 4 cycles, SEL_FORCE=0 -> output sequence 0x11/A, 0x22/B, 0x11/A, 0x22/B; CNT_A=2, CNT_B=2.
- Backpressure: output holds 0x5A/B, OUT_READY=0 for 3 cycles with both sources valid -> OUT_DATA stays 0x5A, READY_A=READY_B=0, counters unchanged. Then OUT_READY=1 -> next word is 0x11 from A.
- Forced select: SEL_FORCE=1, Select_line=1, both valid for 3 cycles -> three words 0x22 tagged B, READY_A=0 throughout, CNT_A unchanged.
- Counter wrap: drive 256 accepted words from A with CNT_WIDTH=8 -> CNT_A returns to 0x00, CNT_B unchanged.
- Mid-operation reset: OUT_VALID=1 holding 0x33, assert RESET=0 between clock edges -> OUT_VALID=0 immediately. After release, A wins the first contention.
